pc_sequencer: RTL and testbench

Per-core instruction sequencer for the TinyGPU. It owns the program counter and the NZP condition register, fetches instructions over a valid/response handshake, and steps the core through decode, execute and PC-update stages. At update it resolves branches as PC+1 versus the branch immediate, selected by the NZP match. It sits between the instruction-memory port and the core datapath and stops when a halt is decoded.

---
 rtl/pc_sequencer_if.sv | 13 +
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port: request (valid + address) out, response (valid + data) back.
interface pc_sequencer_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   req_valid;
  logic [PC_WIDTH-1:0]    req_addr;
  logic                   resp_valid;
  logic [INSTR_WIDTH-1:0] resp_data;

  modport master (output req_valid, req_addr, input resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output resp_valid, resp_data);
endinterface

// File: rtl/pc_sequencer.sv
// TinyGPU per-core sequencer: owns PC and NZP flags, walks each instruction
// through FETCH, DECODE, EXECUTE and UPDATE, and parks in DONE on halt.
module pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  pc_sequencer_if.master         mem,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic                   execute_enable_o,
  input  logic                   nzp_write_enable_i,
  input  logic [2:0]             nzp_in_i,
  input  logic                   branch_enable_i,
  input  logic [2:0]             branch_cond_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  input  logic                   halt_i,
  output logic                   nzp_select_o,
  output logic [PC_WIDTH-1:0]    current_pc_o,
  output logic [2:0]             nzp_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_UPDATE, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [2:0]             nzp_q, nzp_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      nzp_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      nzp_q   <= nzp_d;
      instr_q <= instr_d;
    end
  end

  // Branch decision always uses the flags held before this instruction's update.
  assign nzp_select_o = branch_enable_i & (|(branch_cond_i & nzp_q));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    nzp_d   = nzp_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
          nzp_d   = '0;
        end
      end
      S_FETCH: begin
        if (mem.resp_valid) begin
          instr_d = mem.resp_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        if (halt_i) begin
          state_d = S_DONE;
        end else begin
          pc_d    = nzp_select_o ? branch_target_i : pc_q + PC_WIDTH'(1);
          state_d = S_FETCH;
          if (nzp_write_enable_i) begin
            nzp_d = nzp_in_i;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.req_valid    = (state_q == S_FETCH);
  assign mem.req_addr     = pc_q;
  assign execute_enable_o = (state_q == S_EXECUTE);
  assign done_o           = (state_q == S_DONE);
  assign instruction_o    = instr_q;
  assign current_pc_o     = pc_q;
  assign nzp_o            = nzp_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, hand-written corner
// sequences, and randomized programs against a per-instruction reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [15:0] instruction_o;
  logic        execute_enable_o;
  logic        nzp_write_enable_i;
  logic [2:0]  nzp_in_i;
  logic        branch_enable_i;
  logic [2:0]  branch_cond_i;
  logic [7:0]  branch_target_i;
  logic        halt_i;
  logic        nzp_select_o;
  logic [7:0]  current_pc_o;
  logic [2:0]  nzp_o;
  logic        done_o;

  pc_sequencer_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) imem ();

  pc_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .start_i            (start_i),
    .mem                (imem),
    .instruction_o      (instruction_o),
    .execute_enable_o   (execute_enable_o),
    .nzp_write_enable_i (nzp_write_enable_i),
    .nzp_in_i           (nzp_in_i),
    .branch_enable_i    (branch_enable_i),
    .branch_cond_i      (branch_cond_i),
    .branch_target_i    (branch_target_i),
    .halt_i             (halt_i),
    .nzp_select_o       (nzp_select_o),
    .current_pc_o       (current_pc_o),
    .nzp_o              (nzp_o),
    .done_o             (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int last_exec = -1;

  // Reference state tracked at the instruction level.
  logic [7:0] m_pc;
  logic [2:0] m_nzp;

  typedef struct {
    int         waitc;
    logic [15:0] data;
    logic       we;
    logic [2:0] nin;
    logic       be;
    logic [2:0] bc;
    logic [7:0] bt;
    logic       h;
    logic       exp_sel;
    logic [7:0] exp_pc;
    logic [2:0] exp_nzp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_decoder();
    nzp_write_enable_i = 1'b0;
    nzp_in_i           = 3'b000;
    branch_enable_i    = 1'b0;
    branch_cond_i      = 3'b000;
    branch_target_i    = 8'h00;
    halt_i             = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    check("rst_req_valid", 32'(imem.req_valid), 32'd0);
    check("rst_pc", 32'(current_pc_o), 32'd0);
    check("rst_nzp", 32'(nzp_o), 32'd0);
    check("rst_instr", 32'(instruction_o), 32'd0);
    check("rst_exec", 32'(execute_enable_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    m_pc = 8'h00;
    m_nzp = 3'b000;
    last_exec = -1;
    check("start_pc", 32'(current_pc_o), 32'd0);
    check("start_nzp", 32'(nzp_o), 32'd0);
  endtask

  // Entered one time unit after the edge that puts the DUT in FETCH.
  task automatic run_instr(input int waitc, input logic [15:0] data,
                           input logic we, input logic [2:0] nin,
                           input logic be, input logic [2:0] bc, input logic [7:0] bt,
                           input logic h, input logic exp_sel,
                           input logic [7:0] exp_pc, input logic [2:0] exp_nzp);
    check("fetch_req_valid", 32'(imem.req_valid), 32'd1);
    check("fetch_addr", 32'(imem.req_addr), 32'(m_pc));
    for (int w = 0; w < waitc; w++) begin
      imem.resp_valid = 1'b0;
      @(posedge clk); #1;
      check("wait_req_valid", 32'(imem.req_valid), 32'd1);
      check("wait_addr", 32'(imem.req_addr), 32'(m_pc));
      check("wait_exec", 32'(execute_enable_o), 32'd0);
    end
    imem.resp_valid = 1'b1;
    imem.resp_data  = data;
    @(posedge clk); #1;
    imem.resp_valid = 1'b0;
    imem.resp_data  = 16'($urandom);
    check("decode_instr", 32'(instruction_o), 32'(data));
    check("decode_req_valid", 32'(imem.req_valid), 32'd0);
    check("decode_exec", 32'(execute_enable_o), 32'd0);
    nzp_write_enable_i = we;
    nzp_in_i           = nin;
    branch_enable_i    = be;
    branch_cond_i      = bc;
    branch_target_i    = bt;
    halt_i             = h;
    @(posedge clk); #1;
    check("execute_strobe", 32'(execute_enable_o), 32'd1);
    if (last_exec >= 0) check("exec_spacing", 32'(cyc - last_exec), 32'(4 + waitc));
    last_exec = cyc;
    @(posedge clk); #1;
    check("update_exec", 32'(execute_enable_o), 32'd0);
    check("nzp_select", 32'(nzp_select_o), 32'(exp_sel));
    @(posedge clk); #1;
    clear_decoder();
    check("next_pc", 32'(current_pc_o), 32'(exp_pc));
    check("next_nzp", 32'(nzp_o), 32'(exp_nzp));
    check("next_done", 32'(done_o), 32'(h));
    check("next_req_valid", 32'(imem.req_valid), 32'(!h));
    check("instr_hold", 32'(instruction_o), 32'(data));
    m_pc  = exp_pc;
    m_nzp = exp_nzp;
  endtask

  task automatic vec_set(input int i, input int waitc, input logic [15:0] data,
                         input logic we, input logic [2:0] nin, input logic be,
                         input logic [2:0] bc, input logic [7:0] bt, input logic h,
                         input logic exp_sel, input logic [7:0] exp_pc, input logic [2:0] exp_nzp);
    vecs[i].waitc = waitc; vecs[i].data = data; vecs[i].we = we; vecs[i].nin = nin;
    vecs[i].be = be; vecs[i].bc = bc; vecs[i].bt = bt; vecs[i].h = h;
    vecs[i].exp_sel = exp_sel; vecs[i].exp_pc = exp_pc; vecs[i].exp_nzp = exp_nzp;
  endtask

  initial begin
    logic        r_we, r_be, r_h, taken;
    logic [2:0]  r_nin, r_bc, r_nzp;
    logic [7:0]  r_bt, r_pc;
    int          r_wait;

    reset_i = 1'b1;
    start_i = 1'b0;
    imem.resp_valid = 1'b0;
    imem.resp_data  = 16'h0000;
    clear_decoder();

    //        i wait data      we nin     be bc      bt     h  sel pc     nzp
    vec_set(0, 0, 16'h1100, 0, 3'b000, 0, 3'b000, 8'h00, 0, 0, 8'h01, 3'b000);
    vec_set(1, 0, 16'h2201, 1, 3'b010, 0, 3'b000, 8'h00, 0, 0, 8'h02, 3'b010);
    vec_set(2, 0, 16'h3302, 0, 3'b000, 1, 3'b010, 8'h20, 0, 1, 8'h20, 3'b010);
    vec_set(3, 1, 16'h4420, 0, 3'b000, 1, 3'b100, 8'h30, 0, 0, 8'h21, 3'b010);
    vec_set(4, 3, 16'h5521, 1, 3'b000, 0, 3'b000, 8'h00, 0, 0, 8'h22, 3'b000);
    vec_set(5, 0, 16'h6622, 1, 3'b001, 1, 3'b001, 8'h40, 0, 0, 8'h23, 3'b001);
    vec_set(6, 2, 16'h7723, 0, 3'b000, 1, 3'b001, 8'hFF, 0, 1, 8'hFF, 3'b001);
    vec_set(7, 0, 16'h88FF, 0, 3'b000, 0, 3'b000, 8'h00, 0, 0, 8'h00, 3'b001);
    vec_set(8, 0, 16'h9900, 1, 3'b100, 1, 3'b001, 8'h55, 1, 1, 8'h00, 3'b001);

    @(posedge clk); #1;
    do_reset();

    // IDLE without Start stays idle.
    @(posedge clk); #1;
    check("idle_no_req", 32'(imem.req_valid), 32'd0);

    // Straight-line program, halt at PC 2, then DONE ignores Start and responses.
    do_start();
    run_instr(0, 16'hA000, 0, 3'b000, 0, 3'b000, 8'h00, 0, 0, 8'h01, 3'b000);
    run_instr(0, 16'hA001, 0, 3'b000, 0, 3'b000, 8'h00, 0, 0, 8'h02, 3'b000);
    run_instr(0, 16'hF002, 0, 3'b000, 0, 3'b000, 8'h00, 1, 0, 8'h02, 3'b000);
    for (int k = 0; k < 3; k++) begin
      start_i = 1'b1;
      imem.resp_valid = 1'b1;
      imem.resp_data  = 16'hDEAD;
      @(posedge clk); #1;
      check("done_hold", 32'(done_o), 32'd1);
      check("done_no_req", 32'(imem.req_valid), 32'd0);
      check("done_pc", 32'(current_pc_o), 32'd2);
      check("done_instr", 32'(instruction_o), 32'hF002);
    end
    start_i = 1'b0;
    imem.resp_valid = 1'b0;

    // Directed table: waits, branches, simultaneous NZP write, wrap, halt.
    do_reset();
    do_start();
    for (int i = 0; i < 9; i++) begin
      run_instr(vecs[i].waitc, vecs[i].data, vecs[i].we, vecs[i].nin, vecs[i].be,
                vecs[i].bc, vecs[i].bt, vecs[i].h, vecs[i].exp_sel,
                vecs[i].exp_pc, vecs[i].exp_nzp);
    end

    // Reset during FETCH at PC 5 with a response in the same cycle.
    do_reset();
    do_start();
    run_instr(0, 16'hB000, 1, 3'b111, 0, 3'b000, 8'h00, 0, 0, 8'h01, 3'b111);
    for (int i = 1; i < 5; i++)
      run_instr(0, 16'hB000 + 16'(i), 0, 3'b000, 0, 3'b000, 8'h00, 0, 0, 8'(i + 1), 3'b111);
    check("pre_reset_addr", 32'(imem.req_addr), 32'd5);
    imem.resp_valid = 1'b1;
    imem.resp_data  = 16'hCAFE;
    do_reset();
    imem.resp_valid = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(imem.req_valid), 32'd0);
    do_start();
    run_instr(1, 16'hC000, 0, 3'b000, 0, 3'b000, 8'h00, 0, 0, 8'h01, 3'b000);

    // Randomized programs against the instruction-level model.
    for (int p = 0; p < 3; p++) begin
      do_reset();
      do_start();
      for (int i = 0; i < 25; i++) begin
        r_wait = int'($urandom_range(0, 3));
        r_we   = 1'($urandom);
        r_nin  = 3'($urandom);
        r_be   = 1'($urandom);
        r_bc   = 3'($urandom);
        r_bt   = 8'($urandom);
        r_h    = (i == 24) || ($urandom_range(0, 19) == 0);
        taken  = r_be && ((r_bc & m_nzp) != 3'b000);
        if (r_h) begin
          r_pc  = m_pc;
          r_nzp = m_nzp;
        end else begin
          r_pc  = taken ? r_bt : 8'((int'(m_pc) + 1) % 256);
          r_nzp = r_we ? r_nin : m_nzp;
        end
        run_instr(r_wait, 16'($urandom), r_we, r_nin, r_be, r_bc, r_bt, r_h,
                  taken, r_pc, r_nzp);
        if (r_h) break;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
